md_unit_ctrl: RTL and testbench



---
 rtl/md_unit_ctrl.sv | 146 ++++++++++++++
 tb/tb_md_unit_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_ctrl
// Description : E-stage multiply/divide unit owning HI/LO, with fixed-latency
//               busy sequencing and a stall request for the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  MDOp,
   input  logic        Start,
   input  logic        MD_D,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        Busy,
   output logic        Stall_MD
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        commit;

   logic signed [63:0] a_sx;
   logic signed [63:0] b_sx;
   logic        [63:0] prod_s;
   logic        [63:0] prod_u;
   logic               div_zero;
   logic               div_ovf;
   logic signed [31:0] divisor_s;
   logic signed [31:0] quot_s;
   logic signed [31:0] rem_s;
   logic        [31:0] divisor_u;
   logic        [31:0] quot_u;
   logic        [31:0] rem_u;
   logic               is_md_op;
   logic               is_div;
   logic               launch;
   logic        [31:0] res_hi_n;
   logic        [31:0] res_lo_n;

   assign a_sx   = {{32{A[31]}}, A};
   assign b_sx   = {{32{B[31]}}, B};
   assign prod_s = a_sx * b_sx;
   assign prod_u = {32'd0, A} * {32'd0, B};

   // Zero and overflow divisors are replaced by 1: the zero case is never
   // committed, and A/1 yields exactly the required 0x80000000 rem 0.
   assign div_zero  = (B == 32'd0);
   assign div_ovf   = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
   assign divisor_s = (div_zero || div_ovf) ? 32'sd1 : $signed(B);
   assign quot_s    = $signed(A) / divisor_s;
   assign rem_s     = $signed(A) % divisor_s;
   assign divisor_u = div_zero ? 32'd1 : B;
   assign quot_u    = A / divisor_u;
   assign rem_u     = A % divisor_u;

   assign is_md_op = (MDOp == OP_MULT) || (MDOp == OP_MULTU) ||
                     (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
   assign is_div   = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
   assign launch   = Start && is_md_op;

   always_comb begin
      res_hi_n = 32'd0;
      res_lo_n = 32'd0;
      case (MDOp)
         OP_MULT:  begin res_hi_n = prod_s[63:32];   res_lo_n = prod_s[31:0];   end
         OP_MULTU: begin res_hi_n = prod_u[63:32];   res_lo_n = prod_u[31:0];   end
         OP_DIV:   begin res_hi_n = 32'(rem_s);      res_lo_n = 32'(quot_s);    end
         OP_DIVU:  begin res_hi_n = rem_u;           res_lo_n = quot_u;         end
         default:  begin res_hi_n = 32'd0;           res_lo_n = 32'd0;          end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         res_hi <= 32'd0;
         res_lo <= 32'd0;
         commit <= 1'b0;
         HI     <= 32'd0;
         LO     <= 32'd0;
         Busy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (launch) begin
                  state  <= RUN;
                  Busy   <= 1'b1;
                  cnt    <= is_div ? DIV_LOAD : MULT_LOAD;
                  res_hi <= res_hi_n;
                  res_lo <= res_lo_n;
                  commit <= !(is_div && div_zero);
               end else if (MDOp == OP_MTHI) begin
                  HI <= A;
               end else if (MDOp == OP_MTLO) begin
                  LO <= A;
               end
            end
            RUN: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= IDLE;
                  Busy  <= 1'b0;
                  if (commit) begin
                     HI <= res_hi;
                     LO <= res_lo;
                  end
               end
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

   // Combinational so the dependent instruction is held during Start itself.
   assign Stall_MD = MD_D && (Start || Busy);

endmodule
`default_nettype wire

// File: tb/tb_md_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit_ctrl
// Description : Self-checking bench for md_unit_ctrl with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  MDOp;
   logic        Start;
   logic        MD_D;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        Busy;
   logic        Stall_MD;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: architectural HI/LO plus a count of remaining busy cycles.
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [31:0] p_hi;
   logic [31:0] p_lo;
   bit          p_ok;
   int          m_rem = 0;

   always #5 clk = ~clk;

   md_unit_ctrl #(
      .MULT_CYCLES(MULT_N),
      .DIV_CYCLES (DIV_N)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .A       (A),
      .B       (B),
      .MDOp    (MDOp),
      .Start   (Start),
      .MD_D    (MD_D),
      .HI      (HI),
      .LO      (LO),
      .Busy    (Busy),
      .Stall_MD(Stall_MD)
   );

   function automatic void compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo, output bit ok);
      logic signed [63:0] sa, sb, sp, sq, sr;
      logic [63:0] ua, ub, up;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      ok = 1'b1;
      hi = 32'd0;
      lo = 32'd0;
      case (op)
         3'd1: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
         3'd2: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
         3'd3: begin
            if (b == 32'd0) ok = 1'b0;
            else begin sq = sa / sb; sr = sa % sb; hi = sr[31:0]; lo = sq[31:0]; end
         end
         3'd4: begin
            if (b == 32'd0) ok = 1'b0;
            else begin up = ua / ub; hi = 32'(ua % ub); lo = up[31:0]; end
         end
         default: ok = 1'b0;
      endcase
   endfunction

   function automatic void model_edge();
      if (reset) begin
         m_hi = 32'd0; m_lo = 32'd0; m_rem = 0;
      end else if (m_rem > 0) begin
         m_rem = m_rem - 1;
         if (m_rem == 0 && p_ok) begin m_hi = p_hi; m_lo = p_lo; end
      end else if (Start && MDOp >= 3'd1 && MDOp <= 3'd4) begin
         compute(MDOp, A, B, p_hi, p_lo, p_ok);
         m_rem = (MDOp >= 3'd3) ? DIV_N : MULT_N;
      end else if (MDOp == 3'd5) begin
         m_hi = A;
      end else if (MDOp == 3'd6) begin
         m_lo = A;
      end
   endfunction

   function automatic bit model_stall();
      return MD_D && (Start || (m_rem > 0));
   endfunction

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 9));
         default: return $urandom;
      endcase
   endfunction

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      Start = 1'b0; MDOp = 3'd0; MD_D = 1'b0; A = 32'd0; B = 32'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1; Start = 1'b1; MDOp = 3'd1; MD_D = 1'b1; A = 32'd3; B = 32'd4;
      #1;
      checks++;
      if (Stall_MD !== 1'b1) begin failures++; $display("FAIL reset_stall got=%b exp=1", Stall_MD); end
      tick(); tick();
      checks++;
      if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0) begin
         failures++; $display("FAIL reset_state got HI=%h LO=%h Busy=%b exp 0/0/0", HI, LO, Busy);
      end
      reset = 1'b0; idle_in(); #1;
      checks++;
      if (Stall_MD !== 1'b0) begin failures++; $display("FAIL reset_idle_stall got=%b exp=0", Stall_MD); end
      tick();
   endtask

   task automatic test_mult();
      A = 32'hFFFF_FFFF; B = 32'd2; MDOp = 3'd1; Start = 1'b1;
      tick();
      idle_in();
      for (int k = 1; k <= MULT_N; k++) begin
         checks++;
         if (Busy !== 1'b1 || HI !== 32'd0 || LO !== 32'd0) begin
            failures++; $display("FAIL mult_busy k=%0d got Busy=%b HI=%h LO=%h exp 1/0/0", k, Busy, HI, LO);
         end
         tick();
      end
      checks++;
      if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFE || Busy !== 1'b0) begin
         failures++; $display("FAIL mult_result got HI=%h LO=%h Busy=%b exp ffffffff/fffffffe/0", HI, LO, Busy);
      end
   endtask

   task automatic test_multu();
      A = 32'hFFFF_FFFF; B = 32'd2; MDOp = 3'd2; Start = 1'b1;
      tick();
      idle_in();
      for (int k = 1; k <= MULT_N; k++) begin
         checks++;
         if (Busy !== 1'b1 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFE) begin
            failures++; $display("FAIL multu_hold k=%0d got Busy=%b HI=%h LO=%h", k, Busy, HI, LO);
         end
         tick();
      end
      checks++;
      if (HI !== 32'h0000_0001 || LO !== 32'hFFFF_FFFE || Busy !== 1'b0) begin
         failures++; $display("FAIL multu_result got HI=%h LO=%h Busy=%b exp 00000001/fffffffe/0", HI, LO, Busy);
      end
   endtask

   task automatic test_div();
      A = 32'hFFFF_FFF9; B = 32'd2; MDOp = 3'd3; Start = 1'b1;
      tick();
      idle_in();
      for (int k = 1; k <= DIV_N; k++) begin
         checks++;
         if (Busy !== 1'b1) begin failures++; $display("FAIL div_busy k=%0d got=%b exp=1", k, Busy); end
         tick();
      end
      checks++;
      if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD || Busy !== 1'b0) begin
         failures++; $display("FAIL div_result got HI=%h LO=%h Busy=%b exp ffffffff/fffffffd/0", HI, LO, Busy);
      end
      // divide by zero: full busy period, HI/LO untouched
      A = 32'd7; B = 32'd0; MDOp = 3'd4; Start = 1'b1;
      tick();
      idle_in();
      for (int k = 1; k <= DIV_N; k++) begin
         checks++;
         if (Busy !== 1'b1) begin failures++; $display("FAIL divz_busy k=%0d got=%b exp=1", k, Busy); end
         tick();
      end
      checks++;
      if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD || Busy !== 1'b0) begin
         failures++; $display("FAIL divz_keep got HI=%h LO=%h Busy=%b exp ffffffff/fffffffd/0", HI, LO, Busy);
      end
      A = 32'h8000_0000; B = 32'hFFFF_FFFF; MDOp = 3'd3; Start = 1'b1;
      tick();
      idle_in();
      repeat (DIV_N) tick();
      checks++;
      if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
         failures++; $display("FAIL div_ovf got HI=%h LO=%h exp 00000000/80000000", HI, LO);
      end
   endtask

   task automatic test_stall();
      A = 32'd100; B = 32'd7; MDOp = 3'd3; Start = 1'b1; MD_D = 1'b1;
      #1;
      checks++;
      if (Stall_MD !== 1'b1) begin failures++; $display("FAIL stall_start got=%b exp=1", Stall_MD); end
      tick();
      Start = 1'b0; MDOp = 3'd0;
      for (int k = 1; k <= DIV_N; k++) begin
         #1;
         checks++;
         if (Stall_MD !== 1'b1) begin failures++; $display("FAIL stall_run k=%0d got=%b exp=1", k, Stall_MD); end
         tick();
      end
      #1;
      checks++;
      if (Stall_MD !== 1'b0 || HI !== 32'd2 || LO !== 32'd14) begin
         failures++; $display("FAIL stall_release got Stall=%b HI=%h LO=%h exp 0/2/e", Stall_MD, HI, LO);
      end
      MD_D = 1'b0; A = 32'd9; B = 32'd9; MDOp = 3'd1; Start = 1'b1;
      for (int k = 0; k <= MULT_N + 1; k++) begin
         #1;
         checks++;
         if (Stall_MD !== 1'b0) begin failures++; $display("FAIL stall_nodep k=%0d got=%b exp=0", k, Stall_MD); end
         tick();
         Start = 1'b0; MDOp = 3'd0;
      end
   endtask

   task automatic test_mtlo();
      idle_in(); A = 32'h1234_5678; MDOp = 3'd6;
      tick();
      checks++;
      if (LO !== 32'h1234_5678 || Busy !== 1'b0) begin
         failures++; $display("FAIL mtlo_idle got LO=%h Busy=%b exp 12345678/0", LO, Busy);
      end
      A = 32'd3; B = 32'd5; MDOp = 3'd1; Start = 1'b1;
      tick();
      Start = 1'b0; MDOp = 3'd6; A = 32'hDEAD_BEEF;
      tick();
      checks++;
      if (LO !== 32'h1234_5678) begin failures++; $display("FAIL mtlo_run got LO=%h exp 12345678", LO); end
      Start = 1'b1; MDOp = 3'd1; A = 32'd100; B = 32'd100;
      tick();
      idle_in();
      tick(); tick(); tick();
      checks++;
      if (HI !== 32'd0 || LO !== 32'd15 || Busy !== 1'b0) begin
         failures++; $display("FAIL mtlo_after got HI=%h LO=%h Busy=%b exp 0/f/0", HI, LO, Busy);
      end
   endtask

   task automatic test_reset_mid_run();
      idle_in(); A = 32'hCAFE_F00D; MDOp = 3'd5;
      tick();
      A = 32'd3; B = 32'd3; MDOp = 3'd1; Start = 1'b1;
      tick();
      idle_in();
      tick(); tick();
      reset = 1'b1;
      tick();
      checks++;
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         failures++; $display("FAIL rst_run got Busy=%b HI=%h LO=%h exp 0/0/0", Busy, HI, LO);
      end
      reset = 1'b0;
      tick(); tick();
      checks++;
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         failures++; $display("FAIL rst_late_commit got Busy=%b HI=%h LO=%h exp 0/0/0", Busy, HI, LO);
      end
   endtask

   task automatic test_back_to_back();
      A = 32'd6; B = 32'd7; MDOp = 3'd1; Start = 1'b1;
      tick();
      idle_in();
      repeat (MULT_N) tick();
      checks++;
      if (HI !== 32'd0 || LO !== 32'd42 || Busy !== 1'b0) begin
         failures++; $display("FAIL b2b_first got HI=%h LO=%h Busy=%b exp 0/2a/0", HI, LO, Busy);
      end
      A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; MDOp = 3'd2; Start = 1'b1;
      tick();
      idle_in();
      checks++;
      if (Busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got Busy=%b exp=1", Busy); end
      repeat (MULT_N) tick();
      checks++;
      if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001 || Busy !== 1'b0) begin
         failures++; $display("FAIL b2b_second got HI=%h LO=%h Busy=%b exp fffffffe/00000001/0", HI, LO, Busy);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         MDOp  = 3'($urandom_range(0, 7));
         Start = ($urandom_range(0, 2) == 0);
         MD_D  = 1'($urandom_range(0, 1));
         A     = pick_val();
         B     = pick_val();
         #1;
         checks++;
         if (Stall_MD !== model_stall()) begin
            failures++; $display("FAIL rand_stall c=%0d got=%b exp=%b", c, Stall_MD, model_stall());
         end
         tick();
         checks++;
         if (HI !== m_hi || LO !== m_lo || Busy !== (m_rem > 0)) begin
            failures++;
            $display("FAIL rand_state c=%0d got HI=%h LO=%h Busy=%b exp HI=%h LO=%h Busy=%b",
                     c, HI, LO, Busy, m_hi, m_lo, (m_rem > 0));
         end
      end
      reset = 1'b0; idle_in();
      repeat (DIV_N + 1) tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      idle_in();
      reset = 1'b1;
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_stall();
      test_mtlo();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
